jpeg_fetch_ctrl: RTL and testbench
==================================

JPEG_FETCH_CTRL -- requirements
Module: jpeg_fetch_ctrl

Interface
REQ-001 The block SHALL have one parameter: FIFO_DEPTH, default 8, response FIFO depth in 32-bit words (power of 2, >=2).
REQ-002 The block SHALL have the following ports, one per line:
- clk_i  in  1  single clock
- rst_i  in  1  reset, asynchronous, active-high
- start_i  in  1  start fetch; sampled in IDLE only
- abort_i  in  1  abort current job
- src_addr_i  in  32  JPEG stream byte address; bits [1:0] ignored
- src_len_i  in  32  stream length in bytes
- mem_req_o  out  1  memory read request
- mem_addr_o  out  32  word-aligned read address
- mem_accept_i  in  1  request accepted
- mem_resp_valid_i  in  1  read data valid, in request order
- mem_resp_data_i  in  32  read data, byte 0 in bits [7:0]
- outport_valid_o  out  1  stream word valid to decoder
- outport_data_o  out  32  stream word
- outport_strb_o  out  4  byte enables
- outport_last_o  out  1  final word of stream
- outport_accept_i  in  1  decoder accepts word
- core_idle_i  in  1  decoder pipeline idle
- busy_o  out  1  job in progress
- done_o  out  1  one-cycle completion pulse
- aborted_o  out  1  one-cycle abort-complete pulse

Function
REQ-003 States SHALL be IDLE, FETCH, DRAIN, WAIT_IDLE, ABORT.
REQ-004 IDLE + start_i=1, src_len_i!=0: latch addr (bits [1:0] forced 0), words_total = ceil(len/4), tail = len[1:0]; go to FETCH next cycle.
REQ-005 IDLE + start_i=1, src_len_i=0: no requests, no stream words; done_o=1 the following cycle; remain IDLE.
REQ-006 FETCH: mem_req_o=1 only when (outstanding + fifo_count) < FIFO_DEPTH and words_issued < words_total.
REQ-007 A request SHALL complete on mem_req_o & mem_accept_i; mem_addr_o then advances by 4, wrapping modulo 2^32; mem_addr_o/mem_req_o SHALL hold while unaccepted.
REQ-008 Outstanding counter: +1 on accepted request, -1 on mem_resp_valid_i; simultaneous events leave it unchanged.
REQ-009 Every response SHALL be written to the FIFO; the credit rule guarantees no overflow; a response with zero outstanding is ignored.
REQ-010 When words_issued reaches words_total, FETCH -> DRAIN.
REQ-011 outport_valid_o = FIFO not empty in FETCH/DRAIN; data = FIFO head; word pops on valid & accept.
REQ-012 outport_strb_o = 4'b1111 except the last word: tail 1 -> 4'b0001, 2 -> 4'b0011, 3 -> 4'b0111, 0 -> 4'b1111.
REQ-013 outport_last_o=1 only for word index words_total-1.
REQ-014 DRAIN -> WAIT_IDLE the cycle after the last word is accepted.
REQ-015 WAIT_IDLE: when core_idle_i=1, pulse done_o one cycle, go IDLE.
REQ-016 abort_i in FETCH/DRAIN/WAIT_IDLE -> ABORT: stop requests (in-flight unaccepted request withdrawn), outport_valid_o=0, flush FIFO.
REQ-017 ABORT: discard responses until outstanding=0, then pulse aborted_o one cycle, go IDLE; abort_i in IDLE/ABORT ignored.
REQ-018 busy_o=1 in every state except IDLE.
REQ-019 start_i outside IDLE SHALL be ignored.
REQ-020 Latency: first mem_req_o one cycle after start; FIFO write-to-outport_valid_o one cycle.

Reset
REQ-021 rst_i=1 asynchronously forces IDLE; counters, FIFO pointers, latched config cleared; all outputs 0 (mem_addr_o=0, strb=0).
REQ-022 Reset mid-job abandons it without done_o/aborted_o; responses arriving after reset deassertion are ignored (outstanding=0).

Verification
REQ-023 addr=0x1003, len=10, mem always accepts, 1-cycle responses -> requests at 0x1000,0x1004,0x1008; 3 words, strbs 1111,1111,0011, last on word 3; done_o after core_idle_i.
REQ-024 len=8, FIFO_DEPTH=8, outport_accept_i=0 for 50 cycles -> never more than 8 outstanding+buffered; 2 words delivered in order once accepted.
REQ-025 len=0 start -> no mem_req_o, no outport_valid_o, done_o pulse next cycle, busy_o stays 0.
REQ-026 len=64, abort_i after 5 accepted requests with 3 responses pending -> no further requests, 3 responses discarded, aborted_o pulse, no done_o.
REQ-027 addr=0xFFFFFFFC, len=8 -> mem_addr_o 0xFFFFFFFC then 0x00000000.
REQ-028 rst_i asserted mid-FETCH without a clock edge -> outputs 0 immediately; a subsequent start with len=4 completes normally with one word, strb 1111, last=1.

Source files
------------

// File: rtl/jpeg_fetch_ctrl.sv
// JPEG bitstream fetch controller: issues word-aligned reads for a byte-length job,
// buffers responses in a credit-limited FIFO and streams words with byte enables.
module jpeg_fetch_ctrl #(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [31:0] src_addr_i,
  input  logic [31:0] src_len_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_accept_i,
  input  logic        mem_resp_valid_i,
  input  logic [31:0] mem_resp_data_i,
  output logic        outport_valid_o,
  output logic [31:0] outport_data_o,
  output logic [3:0]  outport_strb_o,
  output logic        outport_last_o,
  input  logic        outport_accept_i,
  input  logic        core_idle_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        aborted_o
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = CW + 1;
  localparam logic [CW:0] DEPTH_L = SW'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, WAIT_IDLE, ABORT} state_t;

  state_t        state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   words_total_q, words_total_d;
  logic [31:0]   words_issued_q, words_issued_d;
  logic [31:0]   out_idx_q, out_idx_d;
  logic [1:0]    tail_q, tail_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] fifo_count_q, fifo_count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          done_q, done_d;
  logic          aborted_q, aborted_d;

  logic [31:0]   fifo_mem [FIFO_DEPTH];

  logic          mem_req;
  logic          req_fire;
  logic          resp_take;
  logic          fifo_push;
  logic          fifo_pop;
  logic          out_valid;
  logic          is_last;
  logic [CW:0]   inflight;
  logic [3:0]    last_strb;

  // Outstanding plus buffered words never exceeds FIFO_DEPTH, so pushes cannot overflow.
  always_comb begin
    inflight  = {1'b0, outstanding_q} + {1'b0, fifo_count_q};
    mem_req   = (state_q == FETCH) && !abort_i && (inflight < DEPTH_L) &&
                (words_issued_q < words_total_q);
    req_fire  = mem_req && mem_accept_i;
    resp_take = mem_resp_valid_i && (outstanding_q != '0);
    fifo_push = resp_take && ((state_q == FETCH) || (state_q == DRAIN));
    out_valid = ((state_q == FETCH) || (state_q == DRAIN)) && (fifo_count_q != '0);
    fifo_pop  = out_valid && outport_accept_i;
    is_last   = (out_idx_q == (words_total_q - 32'd1));
    case (tail_q)
      2'd1:    last_strb = 4'b0001;
      2'd2:    last_strb = 4'b0011;
      2'd3:    last_strb = 4'b0111;
      default: last_strb = 4'b1111;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    words_total_d  = words_total_q;
    words_issued_d = words_issued_q;
    out_idx_d      = out_idx_q;
    tail_d         = tail_q;
    outstanding_d  = outstanding_q;
    fifo_count_d   = fifo_count_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    done_d         = 1'b0;
    aborted_d      = 1'b0;

    if (req_fire) begin
      addr_d         = addr_q + 32'd4;
      words_issued_d = words_issued_q + 32'd1;
    end
    case ({req_fire, resp_take})
      2'b10:   outstanding_d = outstanding_q + CW'(1);
      2'b01:   outstanding_d = outstanding_q - CW'(1);
      default: outstanding_d = outstanding_q;
    endcase
    if (fifo_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (fifo_pop) begin
      rd_ptr_d  = rd_ptr_q + PW'(1);
      out_idx_d = out_idx_q + 32'd1;
    end
    case ({fifo_push, fifo_pop})
      2'b10:   fifo_count_d = fifo_count_q + CW'(1);
      2'b01:   fifo_count_d = fifo_count_q - CW'(1);
      default: fifo_count_d = fifo_count_q;
    endcase

    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (src_len_i == '0) begin
            done_d = 1'b1;
          end else begin
            addr_d         = src_addr_i & ~32'h3;
            words_total_d  = {2'b00, src_len_i[31:2]} + {31'b0, |src_len_i[1:0]};
            tail_d         = src_len_i[1:0];
            words_issued_d = '0;
            out_idx_d      = '0;
            state_d        = FETCH;
          end
        end
      end
      FETCH, DRAIN: begin
        if ((state_q == FETCH) && req_fire && (words_issued_d == words_total_q)) state_d = DRAIN;
        if (fifo_pop && is_last) state_d = WAIT_IDLE;
        if (abort_i) state_d = ABORT;
      end
      WAIT_IDLE: begin
        if (abort_i) begin
          state_d = ABORT;
        end else if (core_idle_i) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      ABORT: begin
        if (outstanding_q == '0) begin
          aborted_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Entering or sitting in ABORT keeps the FIFO flushed; late responses only retire credit.
    if (state_d == ABORT) begin
      fifo_count_d = '0;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      words_total_q  <= '0;
      words_issued_q <= '0;
      out_idx_q      <= '0;
      tail_q         <= '0;
      outstanding_q  <= '0;
      fifo_count_q   <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      done_q         <= 1'b0;
      aborted_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      words_total_q  <= words_total_d;
      words_issued_q <= words_issued_d;
      out_idx_q      <= out_idx_d;
      tail_q         <= tail_d;
      outstanding_q  <= outstanding_d;
      fifo_count_q   <= fifo_count_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      done_q         <= done_d;
      aborted_q      <= aborted_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (fifo_push) fifo_mem[wr_ptr_q] <= mem_resp_data_i;
  end

  assign mem_req_o       = mem_req;
  assign mem_addr_o      = addr_q;
  assign outport_valid_o = out_valid;
  assign outport_data_o  = out_valid ? fifo_mem[rd_ptr_q] : '0;
  assign outport_strb_o  = !out_valid ? 4'b0000 : (is_last ? last_strb : 4'b1111);
  assign outport_last_o  = out_valid && is_last;
  assign busy_o          = (state_q != IDLE);
  assign done_o          = done_q;
  assign aborted_o       = aborted_q;

endmodule

// File: tb/tb_jpeg_fetch_ctrl.sv
// Directed bench for jpeg_fetch_ctrl: cycle vector table plus hand-written
// sequences for backpressure, abort, address wrap and asynchronous reset.
module tb_jpeg_fetch_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        start_i = 1'b0;
  logic        abort_i = 1'b0;
  logic [31:0] src_addr_i = '0;
  logic [31:0] src_len_i = '0;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_accept_i = 1'b0;
  logic        mem_resp_valid_i = 1'b0;
  logic [31:0] mem_resp_data_i = '0;
  logic        outport_valid_o;
  logic [31:0] outport_data_o;
  logic [3:0]  outport_strb_o;
  logic        outport_last_o;
  logic        outport_accept_i = 1'b0;
  logic        core_idle_i = 1'b0;
  logic        busy_o;
  logic        done_o;
  logic        aborted_o;

  always #5 clk_i = ~clk_i;

  jpeg_fetch_ctrl #(.FIFO_DEPTH(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
    .src_addr_i(src_addr_i), .src_len_i(src_len_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_accept_i(mem_accept_i),
    .mem_resp_valid_i(mem_resp_valid_i), .mem_resp_data_i(mem_resp_data_i),
    .outport_valid_o(outport_valid_o), .outport_data_o(outport_data_o),
    .outport_strb_o(outport_strb_o), .outport_last_o(outport_last_o),
    .outport_accept_i(outport_accept_i), .core_idle_i(core_idle_i),
    .busy_o(busy_o), .done_o(done_o), .aborted_o(aborted_o)
  );

  localparam logic [31:0] MAGIC = 32'hA5A5_0000;

  typedef struct {
    logic        start;
    logic [31:0] addr;
    logic [31:0] len;
    logic        acc;
    logic        rv;
    logic [31:0] rd;
    logic        oacc;
    logic        cidle;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_data;
    logic [3:0]  e_strb;
    logic        e_last;
    logic        e_busy;
    logic        e_done;
  } vec_t;

  vec_t tbl[$];

  int n_pass = 0;
  int n_total = 0;

  bit          auto_resp = 1'b0;
  logic [31:0] pend_q[$];
  logic [31:0] req_addr_q[$];
  logic [31:0] got_data[$];
  logic [3:0]  got_strb[$];
  logic        got_last[$];
  int          acc_cnt, pop_cnt, done_cnt, abrt_cnt, max_infl, abrt_pend;
  logic        s_req, s_valid, s_busy;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  task automatic clear_mon();
    pend_q.delete(); req_addr_q.delete();
    got_data.delete(); got_strb.delete(); got_last.delete();
    acc_cnt = 0; pop_cnt = 0; done_cnt = 0; abrt_cnt = 0; max_infl = 0; abrt_pend = -1;
  endtask

  // One cycle: memory model drives a response at negedge, outputs sampled 1ns later.
  task automatic step();
    @(negedge clk_i);
    if (auto_resp && pend_q.size() != 0) begin
      mem_resp_valid_i = 1'b1;
      mem_resp_data_i  = pend_q.pop_front();
    end else begin
      mem_resp_valid_i = 1'b0;
      mem_resp_data_i  = '0;
    end
    #1;
    s_req = mem_req_o; s_valid = outport_valid_o; s_busy = busy_o;
    if (mem_req_o && mem_accept_i) begin
      acc_cnt++;
      req_addr_q.push_back(mem_addr_o);
      pend_q.push_back(mem_addr_o ^ MAGIC);
    end
    if (outport_valid_o && outport_accept_i) begin
      pop_cnt++;
      got_data.push_back(outport_data_o);
      got_strb.push_back(outport_strb_o);
      got_last.push_back(outport_last_o);
    end
    if (done_o) done_cnt++;
    if (aborted_o) begin
      abrt_cnt++;
      abrt_pend = pend_q.size();
    end
    if (acc_cnt - pop_cnt > max_infl) max_infl = acc_cnt - pop_cnt;
    @(posedge clk_i);
    #1;
  endtask

  task automatic reset_dut();
    rst_i = 1'b1;
    start_i = 1'b0; abort_i = 1'b0; mem_accept_i = 1'b0; mem_resp_valid_i = 1'b0;
    outport_accept_i = 1'b0; core_idle_i = 1'b0; auto_resp = 1'b0;
    clear_mon();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic start_job(input logic [31:0] a, input logic [31:0] l);
    src_addr_i = a; src_len_i = l; start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int lim);
    for (int k = 0; k < lim && done_cnt == 0; k++) step();
    chk(nm, done_cnt, 1);
  endtask

  initial begin
    int pop_base;
    int done_base;
    int abrt_base;

    // Basic job 0x1003/len 10, then start ignored in WAIT_IDLE, then a zero-length job.
    tbl.push_back('{1'b1, 32'h1003, 32'd10, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0,
                    1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 32'h0, 32'd0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0,
                    1'b1, 32'h1000, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 32'h0, 32'd0, 1'b1, 1'b1, 32'h1111_1111, 1'b0, 1'b0,
                    1'b1, 32'h1004, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 32'h0, 32'd0, 1'b1, 1'b1, 32'h2222_2222, 1'b1, 1'b0,
                    1'b1, 32'h1008, 1'b1, 32'h1111_1111, 4'hF, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 32'h0, 32'd0, 1'b0, 1'b1, 32'h3333_3333, 1'b1, 1'b0,
                    1'b0, 32'h100C, 1'b1, 32'h2222_2222, 4'hF, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 32'h0, 32'd0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0,
                    1'b0, 32'h100C, 1'b1, 32'h3333_3333, 4'h3, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 32'h0, 32'd0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0,
                    1'b0, 32'h100C, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 32'h9000, 32'd10, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1,
                    1'b0, 32'h100C, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 32'h0, 32'd0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0,
                    1'b0, 32'h100C, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 32'h7000, 32'd0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0,
                    1'b0, 32'h100C, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 32'h0, 32'd0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0,
                    1'b0, 32'h100C, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 32'h0, 32'd0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0,
                    1'b0, 32'h100C, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0});

    // Asynchronous reset takes effect before the first clock edge.
    #1 rst_i = 1'b1;
    #2;
    chk("rst_req", mem_req_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_valid", outport_valid_o, 0);
    chk("rst_strb", outport_strb_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_aborted", aborted_o, 0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;

    foreach (tbl[i]) begin
      @(negedge clk_i);
      start_i = tbl[i].start; src_addr_i = tbl[i].addr; src_len_i = tbl[i].len;
      mem_accept_i = tbl[i].acc; mem_resp_valid_i = tbl[i].rv; mem_resp_data_i = tbl[i].rd;
      outport_accept_i = tbl[i].oacc; core_idle_i = tbl[i].cidle;
      #1;
      chk($sformatf("v%0d_req", i), mem_req_o, tbl[i].e_req);
      chk($sformatf("v%0d_addr", i), mem_addr_o, tbl[i].e_addr);
      chk($sformatf("v%0d_valid", i), outport_valid_o, tbl[i].e_valid);
      chk($sformatf("v%0d_busy", i), busy_o, tbl[i].e_busy);
      chk($sformatf("v%0d_done", i), done_o, tbl[i].e_done);
      if (tbl[i].e_valid) begin
        chk($sformatf("v%0d_data", i), outport_data_o, tbl[i].e_data);
        chk($sformatf("v%0d_strb", i), outport_strb_o, tbl[i].e_strb);
        chk($sformatf("v%0d_last", i), outport_last_o, tbl[i].e_last);
      end
    end

    // Backpressure with a short job: two words held, then delivered in order.
    reset_dut();
    mem_accept_i = 1'b1; auto_resp = 1'b1; core_idle_i = 1'b1;
    start_job(32'h3000, 32'd8);
    repeat (50) step();
    chk("bp8_max_inflight", (max_infl <= 8), 1);
    chk("bp8_requests", acc_cnt, 2);
    chk("bp8_no_pop", pop_cnt, 0);
    chk("bp8_valid_held", s_valid, 1);
    outport_accept_i = 1'b1;
    wait_done("bp8_done", 30);
    chk("bp8_words", got_data.size(), 2);
    if (got_data.size() == 2) begin
      chk("bp8_d0", got_data[0], 32'h3000 ^ MAGIC);
      chk("bp8_d1", got_data[1], 32'h3004 ^ MAGIC);
      chk("bp8_s1", got_strb[1], 4'hF);
      chk("bp8_l0", got_last[0], 0);
      chk("bp8_l1", got_last[1], 1);
    end

    // Credit limit with a long job: exactly FIFO_DEPTH requests until words drain.
    reset_dut();
    mem_accept_i = 1'b1; auto_resp = 1'b1; core_idle_i = 1'b1;
    start_job(32'h6000, 32'd64);
    repeat (50) step();
    chk("credit_requests", acc_cnt, 8);
    chk("credit_max", max_infl, 8);
    chk("credit_req_low", s_req, 0);
    outport_accept_i = 1'b1;
    repeat (20) step();
    chk("credit_resume", (acc_cnt > 8), 1);
    chk("credit_max_after", max_infl, 8);
    if (got_data.size() >= 8) chk("credit_d7", got_data[7], 32'h601C ^ MAGIC);
    else chk("credit_pops", (got_data.size() >= 8), 1);

    // Abort with 5 accepted requests and 3 responses still outstanding.
    reset_dut();
    mem_accept_i = 1'b1; outport_accept_i = 1'b1; core_idle_i = 1'b1;
    start_job(32'h8000, 32'd64);
    for (int k = 0; k < 20 && acc_cnt < 5; k++) step();
    mem_accept_i = 1'b0;
    chk("abort_setup", acc_cnt, 5);
    auto_resp = 1'b1;
    repeat (2) step();
    abort_i = 1'b1; mem_accept_i = 1'b1;
    step();
    abort_i = 1'b0;
    chk("abort_withdrawn", s_req, 0);
    pop_base = pop_cnt;
    for (int k = 0; k < 20 && abrt_cnt == 0; k++) step();
    chk("abort_pulse", abrt_cnt, 1);
    chk("abort_no_new_req", acc_cnt, 5);
    chk("abort_no_done", done_cnt, 0);
    chk("abort_after_resps", abrt_pend, 0);
    chk("abort_no_output", pop_cnt, pop_base);
    step();
    chk("abort_idle", s_busy, 0);
    chk("abort_single_pulse", abrt_cnt, 1);

    // Address wrap at the top of the 32-bit space.
    reset_dut();
    mem_accept_i = 1'b1; auto_resp = 1'b1; outport_accept_i = 1'b1; core_idle_i = 1'b1;
    start_job(32'hFFFF_FFFC, 32'd8);
    wait_done("wrap_done", 30);
    chk("wrap_nreq", req_addr_q.size(), 2);
    if (req_addr_q.size() == 2) begin
      chk("wrap_a0", req_addr_q[0], 32'hFFFF_FFFC);
      chk("wrap_a1", req_addr_q[1], 32'h0000_0000);
    end

    // Asynchronous reset mid-FETCH, stale responses afterwards, then a one-word job.
    clear_mon();
    outport_accept_i = 1'b0;
    start_job(32'h4000, 32'd64);
    repeat (3) step();
    #2 rst_i = 1'b1;
    #1;
    chk("mid_rst_req", mem_req_o, 0);
    chk("mid_rst_addr", mem_addr_o, 0);
    chk("mid_rst_valid", outport_valid_o, 0);
    chk("mid_rst_strb", outport_strb_o, 0);
    chk("mid_rst_last", outport_last_o, 0);
    chk("mid_rst_busy", busy_o, 0);
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    done_base = done_cnt; abrt_base = abrt_cnt; pop_base = pop_cnt;
    outport_accept_i = 1'b1;
    repeat (5) step();
    chk("post_rst_idle", s_busy, 0);
    chk("post_rst_no_pop", pop_cnt, pop_base);
    chk("post_rst_no_done", done_cnt, done_base);
    chk("post_rst_no_abort", abrt_cnt, abrt_base);
    clear_mon();
    start_job(32'h5000, 32'd4);
    wait_done("one_word_done", 30);
    chk("one_word_count", got_data.size(), 1);
    if (got_data.size() == 1) begin
      chk("one_word_data", got_data[0], 32'h5000 ^ MAGIC);
      chk("one_word_strb", got_strb[0], 4'hF);
      chk("one_word_last", got_last[0], 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
